// File: rtl/seg_dma_pkg.sv
// seg_dma_pkg: shared types and constants for the segmented DMA engine.
package seg_dma_pkg;

   // A cache line is 64 bytes, so line offsets are shifted by 6 to form byte addresses.
   localparam int LINE_SHIFT = 6;

   // Default geometry: 512-bit lines of 32-bit words.
   localparam int DEF_WORD_W = 32;
   localparam int DEF_LINE_W = 512;
   localparam int WPL        = DEF_LINE_W / DEF_WORD_W;

   // Transfer sequencing states.
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_GO        = 3'd1,
      S_RD_STREAM = 3'd2,
      S_WR_STREAM = 3'd3,
      S_WR_DRAIN  = 3'd4,
      S_DONE      = 3'd5
   } state_t;

   // Words per line for an arbitrary geometry.
   function automatic int calc_wpl(input int line_w, input int word_w);
      return line_w / word_w;
   endfunction

endpackage

// File: rtl/seg_dma_engine_line_packer.sv
// line_packer: a single cache-line buffer with a word index.
// Pack mode (i_mode = 1) assembles CPU words into a line.
// Unpack mode (i_mode = 0) loads a whole line and hands it out one word at a time.
// Word 0 occupies the least significant bits of the line.
module line_packer #(
   parameter int WORD_W    = 32,
   parameter int LINE_W    = 512,
   parameter int NUM_WORDS = 16,
   localparam int IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_mode,
   input  logic              i_clear,
   input  logic              i_load,
   input  logic [LINE_W-1:0] i_line,
   input  logic              i_word_fire,
   input  logic [WORD_W-1:0] i_word,
   input  logic              i_take,
   output logic              o_full,
   output logic              o_last,
   output logic [WORD_W-1:0] o_word,
   output logic [LINE_W-1:0] o_line
);

   logic [LINE_W-1:0] r_buf;
   logic [IDX_W-1:0]  r_idx;
   logic              r_full;
   logic              w_last;

   assign w_last = (r_idx == IDX_W'(NUM_WORDS - 1));

   // Buffer, word index and occupancy; "full" means a complete line is held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf  <= '0;
         r_idx  <= '0;
         r_full <= 1'b0;
      end else if (i_clear) begin
         r_buf  <= '0;
         r_idx  <= '0;
         r_full <= 1'b0;
      end else if (!i_mode) begin
         if (i_load) begin
            r_buf  <= i_line;
            r_idx  <= '0;
            r_full <= 1'b1;
         end else if (i_word_fire && r_full) begin
            r_idx  <= w_last ? '0 : r_idx + IDX_W'(1);
            r_full <= !w_last;
         end
      end else begin
         if (i_word_fire && !r_full) begin
            r_buf[int'(r_idx)*WORD_W +: WORD_W] <= i_word;
            r_idx  <= w_last ? '0 : r_idx + IDX_W'(1);
            r_full <= w_last;
         end else if (i_take && r_full) begin
            r_full <= 1'b0;
         end
      end
   end

   assign o_full = r_full;
   assign o_last = w_last;
   assign o_word = r_buf[int'(r_idx)*WORD_W +: WORD_W];
   assign o_line = r_buf;

endmodule

// File: rtl/seg_dma_engine.sv
// seg_dma_engine: segment-relative address translation plus multi-line DMA
// read/write sequencing with word packing and unpacking.
// Optional watchdog: define SEG_DMA_WATCHDOG_EN to abort stalled transfers
// with an error after TIMEOUT_CYCLES idle cycles.
//
// Handshakes: a transfer happens on a cycle where both valid and ready are 1
// at the rising clock edge; valid never depends on ready, and the payload is
// held stable while valid is high and ready is low.
module seg_dma_engine
   import seg_dma_pkg::*;
#(
   parameter int WORD_W         = 32,
   parameter int LINE_W         = 512,
   parameter int NUM_SEG        = 4,
   parameter int ADDR_W         = 64,
   parameter int SIZE_W         = 16,
   parameter int TIMEOUT_CYCLES = 65535,
   localparam int SEG_IW        = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [SEG_IW-1:0] cfg_seg,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [SEG_IW:0]   req_seg,
   input  logic [ADDR_W-7:0] req_offset,
   input  logic [SIZE_W-1:0] req_lines,
   input  logic              wr_word_valid,
   output logic              wr_word_ready,
   input  logic [WORD_W-1:0] wr_word,
   output logic              rd_word_valid,
   input  logic              rd_word_ready,
   output logic [WORD_W-1:0] rd_word,
   output logic              xfer_done,
   output logic              xfer_err,
   output logic [ADDR_W-1:0] dma_rd_addr,
   output logic [ADDR_W-1:0] dma_wr_addr,
   output logic [SIZE_W-1:0] dma_rd_size,
   output logic [SIZE_W-1:0] dma_wr_size,
   output logic              dma_rd_go,
   output logic              dma_wr_go,
   output logic              dma_rd_en,
   input  logic [LINE_W-1:0] dma_rd_data,
   input  logic              dma_empty,
   input  logic              dma_rd_done,
   output logic              dma_wr_en,
   output logic [LINE_W-1:0] dma_wr_data,
   input  logic              dma_full,
   input  logic              dma_wr_done,
   output logic [2:0]        dbg_state
);

   localparam int                L_WPL    = calc_wpl(LINE_W, WORD_W);
   localparam logic [SIZE_W-1:0] ONE_LINE = SIZE_W'(1);

   logic [ADDR_W-1:0] r_base [NUM_SEG];
   state_t            r_state;
   logic              r_write;
   logic              r_err;
   logic [ADDR_W-1:0] r_addr;
   logic [SIZE_W-1:0] r_size;
   logic [SIZE_W-1:0] r_lines_left;

   logic              w_accept;
   logic              w_bad_req;
   logic [ADDR_W-1:0] w_addr;
   logic              w_buf_full;
   logic              w_last_word;
   logic              w_rd_en;
   logic              w_wr_en;
   logic              w_rd_fire;
   logic              w_wr_fire;
   logic              w_unused;

   // The read-channel completion is informational only; sequencing uses line counts.
   assign w_unused  = dma_rd_done | (TIMEOUT_CYCLES < 1);

   assign w_accept  = req_valid && (r_state == S_IDLE);
   assign w_bad_req = (req_lines == '0) || (int'(req_seg) >= NUM_SEG);
   assign w_addr    = r_base[req_seg[SEG_IW-1:0]] + (ADDR_W'(req_offset) << LINE_SHIFT);

   assign w_rd_en   = (r_state == S_RD_STREAM) && !w_buf_full && !dma_empty
                      && (r_lines_left != '0);
   assign w_wr_en   = (r_state == S_WR_STREAM) && w_buf_full && !dma_full;
   assign w_rd_fire = rd_word_valid && rd_word_ready;
   assign w_wr_fire = wr_word_valid && wr_word_ready;

   // Base table: writable in any state; in-flight transfers use their latched address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SEG; i++) r_base[i] <= '0;
      end else if (cfg_we && (int'(cfg_seg) < NUM_SEG)) begin
         r_base[cfg_seg] <= cfg_base;
      end
   end

`ifdef SEG_DMA_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] r_wd_cnt;
   logic            w_wd_active;
   logic            w_wd_kick;
   logic            w_wd_expire;

   assign w_wd_active = (r_state == S_GO) || (r_state == S_RD_STREAM)
                        || (r_state == S_WR_STREAM) || (r_state == S_WR_DRAIN);
   assign w_wd_kick   = w_rd_en || w_wr_en || w_rd_fire || w_wr_fire || dma_wr_done;
   assign w_wd_expire = w_wd_active && !w_wd_kick
                        && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   // Idle-cycle counter; any forward progress restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wd_cnt <= '0;
      end else if (!w_wd_active || w_wd_kick) begin
         r_wd_cnt <= '0;
      end else begin
         r_wd_cnt <= r_wd_cnt + WD_W'(1);
      end
   end
`endif

   // Transfer sequencer: accept, start pulse, stream lines, wait for write drain, report.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_write      <= 1'b0;
         r_err        <= 1'b0;
         r_addr       <= '0;
         r_size       <= '0;
         r_lines_left <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_write      <= req_write;
                  r_addr       <= w_addr;
                  r_size       <= req_lines;
                  r_lines_left <= req_lines;
                  r_err        <= w_bad_req;
                  r_state      <= w_bad_req ? S_DONE : S_GO;
               end
            end
            S_GO: r_state <= r_write ? S_WR_STREAM : S_RD_STREAM;
            S_RD_STREAM: begin
               if (w_rd_en) r_lines_left <= r_lines_left - ONE_LINE;
               if (w_rd_fire && w_last_word && (r_lines_left == '0)) r_state <= S_DONE;
            end
            S_WR_STREAM: begin
               if (w_wr_en) begin
                  r_lines_left <= r_lines_left - ONE_LINE;
                  if (r_lines_left == ONE_LINE) r_state <= S_WR_DRAIN;
               end
            end
            S_WR_DRAIN: if (dma_wr_done) r_state <= S_DONE;
            S_DONE: begin
               r_state <= S_IDLE;
               r_err   <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
`ifdef SEG_DMA_WATCHDOG_EN
         if (w_wd_expire) begin
            r_state <= S_DONE;
            r_err   <= 1'b1;
         end
`endif
      end
   end

   line_packer #(
      .WORD_W   (WORD_W),
      .LINE_W   (LINE_W),
      .NUM_WORDS(L_WPL)
   ) u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_mode     (r_write),
      .i_clear    (w_accept),
      .i_load     (w_rd_en),
      .i_line     (dma_rd_data),
      .i_word_fire(r_write ? w_wr_fire : w_rd_fire),
      .i_word     (wr_word),
      .i_take     (w_wr_en),
      .o_full     (w_buf_full),
      .o_last     (w_last_word),
      .o_word     (rd_word),
      .o_line     (dma_wr_data)
   );

   assign req_ready     = (r_state == S_IDLE);
   assign wr_word_ready = (r_state == S_WR_STREAM) && !w_buf_full;
   assign rd_word_valid = (r_state == S_RD_STREAM) && w_buf_full;
   assign xfer_done     = (r_state == S_DONE);
   assign xfer_err      = (r_state == S_DONE) && r_err;
   assign dma_rd_go     = (r_state == S_GO) && !r_write;
   assign dma_wr_go     = (r_state == S_GO) && r_write;
   assign dma_rd_en     = w_rd_en;
   assign dma_wr_en     = w_wr_en;
   assign dma_rd_addr   = r_addr;
   assign dma_wr_addr   = r_addr;
   assign dma_rd_size   = r_size;
   assign dma_wr_size   = r_size;
   assign dbg_state     = r_state;

endmodule
